// File: rtl/axi_wr_route_ctrl.sv
// Write-path routing controller for a 1-master / 2-slave AXI4 slice.
// Locks the slave route at AW acceptance and holds it through W and B.
module axi_wr_route_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BIT    = 31,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [ADDR_WIDTH-1:0] S_AWADDR,
  input  logic [7:0]            S_AWLEN,
  input  logic                  S_WVALID,
  input  logic                  S_WLAST,
  output logic                  S_WREADY,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  output logic                  M0_AWVALID,
  output logic                  M1_AWVALID,
  input  logic                  M0_AWREADY,
  input  logic                  M1_AWREADY,
  input  logic                  M0_WREADY,
  input  logic                  M1_WREADY,
  input  logic                  M0_BVALID,
  input  logic                  M1_BVALID,
  output logic                  M0_BREADY,
  output logic                  M1_BREADY,
  output logic                  w_sel,
  output logic                  w_en,
  output logic                  b_sel,
  output logic                  busy,
  output logic                  len_err,
  output logic [CNT_WIDTH-1:0]  txn_cnt0,
  output logic [CNT_WIDTH-1:0]  txn_cnt1
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_sel;
  logic [7:0]           r_len;
  logic [7:0]           r_beat_cnt;
  logic                 r_len_err;
  logic [CNT_WIDTH-1:0] r_txn_cnt0;
  logic [CNT_WIDTH-1:0] r_txn_cnt1;

  logic w_slv_awready;
  logic w_slv_wready;
  logic w_slv_bvalid;
  logic w_aw_hs;
  logic w_beat;
  logic w_at_len;
  logic w_last_beat;
  logic w_b_hs;
  logic w_unused_addr;

  assign w_slv_awready = r_sel ? M1_AWREADY : M0_AWREADY;
  assign w_slv_wready  = r_sel ? M1_WREADY  : M0_WREADY;
  assign w_slv_bvalid  = r_sel ? M1_BVALID  : M0_BVALID;

  // Handshakes are derived from the gated outputs, so they can only fire in their own state.
  assign w_aw_hs     = (M0_AWVALID & M0_AWREADY) | (M1_AWVALID & M1_AWREADY);
  assign w_beat      = S_WVALID & S_WREADY;
  assign w_at_len    = (r_beat_cnt == r_len);
  assign w_last_beat = w_beat & w_at_len;
  assign w_b_hs      = S_BVALID & S_BREADY;

  assign w_unused_addr = ^S_AWADDR;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (S_AWVALID)   w_next_state = ADDR;
      ADDR: if (w_aw_hs)     w_next_state = DATA;
      DATA: if (w_last_beat) w_next_state = RESP;
      RESP: if (w_b_hs)      w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  always_comb begin
    S_AWREADY  = 1'b0;
    S_WREADY   = 1'b0;
    S_BVALID   = 1'b0;
    M0_AWVALID = 1'b0;
    M1_AWVALID = 1'b0;
    M0_BREADY  = 1'b0;
    M1_BREADY  = 1'b0;
    w_en       = 1'b0;
    b_sel      = 1'b0;
    w_sel      = r_sel;
    case (r_state)
      ADDR: begin
        M0_AWVALID = ~r_sel;
        M1_AWVALID = r_sel;
        S_AWREADY  = w_slv_awready;
      end
      DATA: begin
        w_en     = 1'b1;
        S_WREADY = w_slv_wready;
      end
      RESP: begin
        b_sel     = r_sel;
        S_BVALID  = w_slv_bvalid;
        M0_BREADY = ~r_sel & S_BREADY;
        M1_BREADY = r_sel & S_BREADY;
      end
      default: ;
    endcase
  end

  // Beat counter stops at len, so a 256-beat burst never wraps it.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_sel      <= 1'b0;
      r_len      <= 8'd0;
      r_beat_cnt <= 8'd0;
      r_len_err  <= 1'b0;
      r_txn_cnt0 <= '0;
      r_txn_cnt1 <= '0;
    end else begin
      if (r_state == IDLE && S_AWVALID) begin
        r_sel      <= S_AWADDR[SEL_BIT];
        r_len      <= S_AWLEN;
        r_beat_cnt <= 8'd0;
      end else if (w_beat && !w_at_len) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_beat && (S_WLAST != w_at_len)) begin
        r_len_err <= 1'b1;
      end
      if (w_b_hs && !r_sel) begin
        r_txn_cnt0 <= r_txn_cnt0 + CNT_ONE;
      end
      if (w_b_hs && r_sel) begin
        r_txn_cnt1 <= r_txn_cnt1 + CNT_ONE;
      end
    end
  end

  assign busy     = (r_state != IDLE);
  assign len_err  = r_len_err;
  assign txn_cnt0 = r_txn_cnt0;
  assign txn_cnt1 = r_txn_cnt1;

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
// Directed bench for axi_wr_route_ctrl; counters built 2 bits wide so wrap is reachable.
module tb_axi_wr_route_ctrl;

  logic        ACLK;
  logic        ARESETN;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_AWADDR;
  logic [7:0]  S_AWLEN;
  logic        S_WVALID;
  logic        S_WLAST;
  logic        S_WREADY;
  logic        S_BVALID;
  logic        S_BREADY;
  logic        M0_AWVALID, M1_AWVALID;
  logic        M0_AWREADY, M1_AWREADY;
  logic        M0_WREADY, M1_WREADY;
  logic        M0_BVALID, M1_BVALID;
  logic        M0_BREADY, M1_BREADY;
  logic        w_sel, w_en, b_sel, busy, len_err;
  logic [1:0]  txn_cnt0, txn_cnt1;

  int nCompared = 0;
  int nFailed   = 0;

  axi_wr_route_ctrl #(.ADDR_WIDTH(32), .SEL_BIT(31), .CNT_WIDTH(2)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
    .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M0_AWVALID(M0_AWVALID), .M1_AWVALID(M1_AWVALID),
    .M0_AWREADY(M0_AWREADY), .M1_AWREADY(M1_AWREADY),
    .M0_WREADY(M0_WREADY), .M1_WREADY(M1_WREADY),
    .M0_BVALID(M0_BVALID), .M1_BVALID(M1_BVALID),
    .M0_BREADY(M0_BREADY), .M1_BREADY(M1_BREADY),
    .w_sel(w_sel), .w_en(w_en), .b_sel(b_sel), .busy(busy), .len_err(len_err),
    .txn_cnt0(txn_cnt0), .txn_cnt1(txn_cnt1)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idleInputs();
    S_AWVALID = 0; S_AWADDR = '0; S_AWLEN = '0; S_WVALID = 0; S_WLAST = 0; S_BREADY = 0;
    M0_AWREADY = 0; M1_AWREADY = 0; M0_WREADY = 0; M1_WREADY = 0; M0_BVALID = 0; M1_BVALID = 0;
  endtask

  // Runs one transaction with every ready high and a correctly placed WLAST.
  task automatic doTxn(input logic [31:0] addr, input logic [7:0] len, output int beats, output bit done);
    logic awHs, beatHs, bHs;
    beats = 0;
    done  = 0;
    S_AWADDR = addr; S_AWLEN = len; S_AWVALID = 1;
    M0_AWREADY = 1; M1_AWREADY = 1; M0_WREADY = 1; M1_WREADY = 1;
    M0_BVALID = 1; M1_BVALID = 1; S_BREADY = 1; S_WVALID = 1;
    for (int k = 0; k < 1000 && !done; k++) begin
      S_WLAST = (beats == int'(len));
      #1;
      awHs   = S_AWVALID & S_AWREADY;
      beatHs = S_WVALID & S_WREADY;
      bHs    = S_BVALID & S_BREADY;
      tick();
      if (awHs) S_AWVALID = 0;
      if (beatHs) beats++;
      if (bHs) done = 1;
    end
    idleInputs();
  endtask

  task automatic test_reset();
    idleInputs();
    ARESETN = 0;
    repeat (2) tick();
    nCompared++; if ({S_AWREADY, S_WREADY, S_BVALID, M0_AWVALID, M1_AWVALID, M0_BREADY, M1_BREADY, w_sel, w_en, b_sel, busy, len_err, txn_cnt0, txn_cnt1} !== 16'h0) begin nFailed++; $display("[TB] FAIL reset_outputs got=%h exp=0000", {S_AWREADY, S_WREADY, S_BVALID, M0_AWVALID, M1_AWVALID, M0_BREADY, M1_BREADY, w_sel, w_en, b_sel, busy, len_err, txn_cnt0, txn_cnt1}); end
    ARESETN = 1;
    repeat (2) tick();
    nCompared++; if (busy !== 1'b0) begin nFailed++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
    nCompared++; if (S_AWREADY !== 1'b0) begin nFailed++; $display("[TB] FAIL idle_awready got=%b exp=0", S_AWREADY); end
  endtask

  task automatic test_route_slave1();
    int enCnt, m1AwCnt;
    logic m0Seen;
    enCnt = 0; m1AwCnt = 0; m0Seen = 0;
    idleInputs();
    S_AWVALID = 1; S_AWADDR = 32'h8000_0000; S_AWLEN = 8'd3;
    M0_AWREADY = 1; M1_AWREADY = 1; M0_WREADY = 1; M1_WREADY = 1; S_BREADY = 1;
    #1;
    nCompared++; if (S_AWREADY !== 1'b0) begin nFailed++; $display("[TB] FAIL s1_idle_awready got=%b exp=0", S_AWREADY); end
    tick();
    m1AwCnt += int'(M1_AWVALID); m0Seen |= M0_AWVALID | M0_BREADY;
    nCompared++; if (S_AWREADY !== 1'b1) begin nFailed++; $display("[TB] FAIL s1_addr_awready got=%b exp=1", S_AWREADY); end
    nCompared++; if (w_en !== 1'b0) begin nFailed++; $display("[TB] FAIL s1_addr_wen got=%b exp=0", w_en); end
    tick();
    S_AWVALID = 0; S_WVALID = 1;
    for (int i = 0; i < 4; i++) begin
      S_WLAST = (i == 3);
      #1;
      enCnt += int'(w_en); m1AwCnt += int'(M1_AWVALID); m0Seen |= M0_AWVALID | M0_BREADY;
      nCompared++; if (w_sel !== 1'b1) begin nFailed++; $display("[TB] FAIL s1_wsel beat=%0d got=%b exp=1", i, w_sel); end
      tick();
    end
    S_WVALID = 0; S_WLAST = 0; M1_BVALID = 1;
    #1;
    enCnt += int'(w_en); m0Seen |= M0_AWVALID | M0_BREADY;
    nCompared++; if (enCnt !== 4) begin nFailed++; $display("[TB] FAIL s1_wen_cycles got=%0d exp=4", enCnt); end
    nCompared++; if (b_sel !== 1'b1) begin nFailed++; $display("[TB] FAIL s1_bsel got=%b exp=1", b_sel); end
    nCompared++; if ({S_BVALID, M1_BREADY} !== 2'b11) begin nFailed++; $display("[TB] FAIL s1_bresp got=%b exp=11", {S_BVALID, M1_BREADY}); end
    tick();
    M1_BVALID = 0;
    #1;
    nCompared++; if (busy !== 1'b0) begin nFailed++; $display("[TB] FAIL s1_done_busy got=%b exp=0", busy); end
    nCompared++; if (txn_cnt1 !== 2'd1) begin nFailed++; $display("[TB] FAIL s1_txn_cnt1 got=%0d exp=1", txn_cnt1); end
    nCompared++; if (len_err !== 1'b0) begin nFailed++; $display("[TB] FAIL s1_len_err got=%b exp=0", len_err); end
    nCompared++; if (m0Seen !== 1'b0) begin nFailed++; $display("[TB] FAIL s1_m0_quiet got=%b exp=0", m0Seen); end
    nCompared++; if (m1AwCnt !== 1) begin nFailed++; $display("[TB] FAIL s1_m1_awvalid_cycles got=%0d exp=1", m1AwCnt); end
    idleInputs();
  endtask

  task automatic test_backpressure_slave0();
    idleInputs();
    S_AWVALID = 1; S_AWADDR = 32'h0000_1000; S_AWLEN = 8'd0; M0_BVALID = 1;
    #1;
    nCompared++; if (S_BVALID !== 1'b0) begin nFailed++; $display("[TB] FAIL bp_stray_bvalid got=%b exp=0", S_BVALID); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++; if ({M0_AWVALID, S_AWREADY} !== 2'b10) begin nFailed++; $display("[TB] FAIL bp_aw_wait cyc=%0d got=%b exp=10", i, {M0_AWVALID, S_AWREADY}); end
      tick();
    end
    M0_AWREADY = 1;
    #1;
    nCompared++; if ({S_AWREADY, M1_AWVALID, M0_BREADY} !== 3'b100) begin nFailed++; $display("[TB] FAIL bp_aw_hs got=%b exp=100", {S_AWREADY, M1_AWVALID, M0_BREADY}); end
    tick();
    S_AWVALID = 0; M0_AWREADY = 0; M0_BVALID = 0; S_WVALID = 1; S_WLAST = 1; M0_WREADY = 0;
    #1;
    nCompared++; if ({S_WREADY, w_en, w_sel} !== 3'b010) begin nFailed++; $display("[TB] FAIL bp_w_stall got=%b exp=010", {S_WREADY, w_en, w_sel}); end
    tick();
    M0_WREADY = 1;
    #1;
    nCompared++; if ({S_WREADY, w_en} !== 2'b11) begin nFailed++; $display("[TB] FAIL bp_w_accept got=%b exp=11", {S_WREADY, w_en}); end
    tick();
    S_WVALID = 0; S_WLAST = 0;
    #1;
    nCompared++; if ({w_en, S_BVALID, busy} !== 3'b001) begin nFailed++; $display("[TB] FAIL bp_resp_wait got=%b exp=001", {w_en, S_BVALID, busy}); end
    S_BREADY = 1;
    tick();
    M0_BVALID = 1;
    #1;
    nCompared++; if ({S_BVALID, M0_BREADY, M1_BREADY, b_sel} !== 4'b1100) begin nFailed++; $display("[TB] FAIL bp_bresp got=%b exp=1100", {S_BVALID, M0_BREADY, M1_BREADY, b_sel}); end
    tick();
    M0_BVALID = 0;
    #1;
    nCompared++; if ({busy, txn_cnt0} !== 3'b001) begin nFailed++; $display("[TB] FAIL bp_done got busy,cnt0=%b exp=0,01", {busy, txn_cnt0}); end
    idleInputs();
  endtask

  task automatic test_len256();
    int beats;
    bit done;
    doTxn(32'h7FFF_FFFF, 8'd255, beats, done);
    nCompared++; if (done !== 1'b1) begin nFailed++; $display("[TB] FAIL len256_timeout got=%b exp=1", done); end
    nCompared++; if (beats !== 256) begin nFailed++; $display("[TB] FAIL len256_beats got=%0d exp=256", beats); end
    nCompared++; if ({txn_cnt0, txn_cnt1, len_err} !== 5'b10010) begin nFailed++; $display("[TB] FAIL len256_state got=%b exp=10010", {txn_cnt0, txn_cnt1, len_err}); end
  endtask

  task automatic test_wlast_mismatch();
    idleInputs();
    S_AWVALID = 1; S_AWADDR = 32'h8000_0010; S_AWLEN = 8'd1;
    M0_AWREADY = 1; M1_AWREADY = 1; M0_WREADY = 1; M1_WREADY = 1; S_BREADY = 1;
    tick();
    tick();
    S_AWVALID = 0; S_WVALID = 1; S_WLAST = 1;
    tick();
    S_WLAST = 0;
    #1;
    nCompared++; if ({len_err, w_en} !== 2'b11) begin nFailed++; $display("[TB] FAIL wl_after_beat0 got=%b exp=11", {len_err, w_en}); end
    tick();
    S_WVALID = 0; M1_BVALID = 1;
    #1;
    nCompared++; if ({w_en, S_BVALID} !== 2'b01) begin nFailed++; $display("[TB] FAIL wl_resp got=%b exp=01", {w_en, S_BVALID}); end
    tick();
    M1_BVALID = 0;
    #1;
    nCompared++; if ({len_err, busy, txn_cnt1} !== 4'b1010) begin nFailed++; $display("[TB] FAIL wl_done got=%b exp=1010", {len_err, busy, txn_cnt1}); end
    idleInputs();
  endtask

  task automatic test_min_latency();
    int busyCnt;
    busyCnt = 0;
    idleInputs();
    S_AWVALID = 1; S_AWADDR = 32'h0000_0040; S_AWLEN = 8'd0;
    M0_AWREADY = 1; M0_WREADY = 1; M0_BVALID = 1; S_BREADY = 1; S_WVALID = 1; S_WLAST = 1;
    tick();
    S_AWVALID = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (busy) busyCnt++;
      else break;
      tick();
    end
    nCompared++; if (busyCnt !== 3) begin nFailed++; $display("[TB] FAIL minlat_busy_cycles got=%0d exp=3", busyCnt); end
    nCompared++; if ({txn_cnt0, len_err} !== 3'b111) begin nFailed++; $display("[TB] FAIL minlat_state got=%b exp=111", {txn_cnt0, len_err}); end
    idleInputs();
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    bit done;
    idleInputs();
    S_AWVALID = 1; S_AWADDR = 32'h8000_0000; S_AWLEN = 8'd7;
    M0_AWREADY = 1; M1_AWREADY = 1; M0_WREADY = 1; M1_WREADY = 1;
    tick();
    tick();
    S_AWVALID = 0; S_WVALID = 1; S_WLAST = 0;
    repeat (3) tick();
    ARESETN = 0;
    #1;
    nCompared++; if (w_en !== 1'b1) begin nFailed++; $display("[TB] FAIL rst_mid_before_edge got=%b exp=1", w_en); end
    tick();
    nCompared++; if ({w_en, busy, len_err, w_sel, txn_cnt0, txn_cnt1} !== 8'h00) begin nFailed++; $display("[TB] FAIL rst_mid_cleared got=%b exp=00000000", {w_en, busy, len_err, w_sel, txn_cnt0, txn_cnt1}); end
    idleInputs();
    ARESETN = 1;
    tick();
    doTxn(32'h0000_2000, 8'd1, beats, done);
    nCompared++; if ({done, beats[7:0]} !== 9'h102) begin nFailed++; $display("[TB] FAIL rst_mid_next_txn got done=%b beats=%0d exp 1,2", done, beats); end
    nCompared++; if ({txn_cnt0, txn_cnt1, len_err} !== 5'b01000) begin nFailed++; $display("[TB] FAIL rst_mid_next_state got=%b exp=01000", {txn_cnt0, txn_cnt1, len_err}); end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] expCnt [5];
    int beats;
    bit done;
    expCnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    idleInputs();
    ARESETN = 0;
    tick();
    ARESETN = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      doTxn(32'h8000_0004, 8'(i), beats, done);
      nCompared++; if ({done, txn_cnt1} !== {1'b1, expCnt[i]}) begin nFailed++; $display("[TB] FAIL wrap_txn%0d got done=%b cnt1=%0d exp 1,%0d", i, done, txn_cnt1, expCnt[i]); end
    end
    nCompared++; if (txn_cnt0 !== 2'd0) begin nFailed++; $display("[TB] FAIL wrap_cnt0 got=%0d exp=0", txn_cnt0); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ARESETN = 0;
    idleInputs();
    test_reset();
    test_route_slave1();
    test_backpressure_slave0();
    test_len256();
    test_wlast_mismatch();
    test_min_latency();
    test_reset_mid_burst();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/axi_wr_route_ctrl.md
Name: axi_wr_route_ctrl

Overview:
- Write-path routing controller for a 1-master / 2-slave AXI4 interconnect slice.
- Decodes AWADDR and locks the route for the whole transaction.
- Drives select/enable of the external W-channel 1x2 enable-demux (Demux_1x2_en), gates WREADY, and steers the B response back from the owning slave.
- One transaction outstanding at a time; sits between the master-side AW/W/B ports and the two slave ports.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR.
- SEL_BIT, 31, AWADDR bit that selects the slave (0 -> slave 0, 1 -> slave 1).
- CNT_WIDTH, 16, width of the per-slave completed-transaction counters.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  synchronous active-low reset.
- S_AWVALID  in  1  master AW valid.
- S_AWREADY  out  1  master AW ready.
- S_AWADDR  in  ADDR_WIDTH  master write address.
- S_AWLEN  in  8  burst length minus one.
- S_WVALID  in  1  master W valid; observed for beat counting only, payload goes through the demux.
- S_WLAST  in  1  master W last.
- S_WREADY  out  1  master W ready.
- S_BVALID  out  1  response valid to master.
- S_BREADY  in  1  master response ready.
- M0_AWVALID, M1_AWVALID  out  1 each  AW valid to slave 0/1.
- M0_AWREADY, M1_AWREADY  in  1 each  AW ready from slave 0/1.
- M0_WREADY, M1_WREADY  in  1 each  W ready from slave 0/1.
- M0_BVALID, M1_BVALID  in  1 each  B valid from slave 0/1.
- M0_BREADY, M1_BREADY  out  1 each  B ready to slave 0/1.
- w_sel  out  1  demux select (0 -> out1/slave 0, 1 -> out2/slave 1).
- w_en  out  1  demux enable.
- b_sel  out  1  BRESP/BID mux select.
- busy  out  1  high in any state other than IDLE.
- len_err  out  1  sticky flag: WLAST disagrees with the beat count.
- txn_cnt0, txn_cnt1  out  CNT_WIDTH each  completed transactions per slave.

Behaviour:
- Reset (ARESETN=0 at an edge): state goes to IDLE. Every output is 0, including the counters, len_err, the registered sel, and the beat counter. Reset mid-transaction drops the route immediately; w_en is 0 from the next cycle.
- State register values: IDLE, ADDR, DATA, RESP.
- IDLE:
  - S_AWREADY=0, w_en=0.
  - On S_AWVALID=1: register sel=S_AWADDR[SEL_BIT] and len=S_AWLEN, clear beat counter, go to ADDR.
- ADDR:
  - M{sel}_AWVALID=1; the other slave's AWVALID=0.
  - S_AWREADY = M{sel}_AWREADY (combinational), so both handshakes complete in the same cycle. The AW payload is wired to both slaves externally.
  - On handshake, go to DATA. AW latency from S_AWVALID to earliest AW handshake is 1 cycle.
- DATA:
  - w_en=1, w_sel=sel. S_WREADY = M{sel}_WREADY.
  - A beat is a cycle with S_WVALID & S_WREADY; each beat increments the 8-bit beat counter.
  - On the beat where the counter equals len, go to RESP.
  - On any beat, if S_WLAST != (counter==len), set len_err; it is cleared only by reset. The FSM advances on the count regardless of WLAST.
  - AWLEN=0 is a single-beat burst; AWLEN=255 is 256 beats, with no counter overflow since the count stops at len.
- RESP:
  - w_en=0, b_sel=sel.
  - S_BVALID = M{sel}_BVALID. M{sel}_BREADY = S_BREADY; the other slave's BREADY=0.
  - On handshake: increment txn_cnt{sel} (wraps at 2^CNT_WIDTH - 1 -> 0) and go to IDLE.
- Outside DATA: w_en=0 and S_WREADY=0, so early W data from the master stalls.
- Outside RESP: all BREADY=0 and S_BVALID=0. A stray slave BVALID is ignored.
- Outside ADDR: M0/M1_AWVALID=0.
- w_sel holds the registered sel in every state. Its IDLE value is don't-care but registered (no glitch).
- Minimum transaction length (AWLEN=0, all readies high): 4 cycles, IDLE -> ADDR -> DATA -> RESP -> IDLE.
- busy = (state != IDLE).

Test Plan:
- Reset then idle: ARESETN=0 for 2 cycles, then 1 -> all outputs 0, busy=0; S_AWREADY stays 0 with S_AWVALID=0.
- Route to slave 1: AWADDR=0x8000_0000, AWLEN=3, all readies high, WLAST on 4th beat -> w_sel=1, w_en=1 for exactly 4 cycles; M1_AWVALID pulses; M0_AWVALID/M0_BREADY stay 0; txn_cnt1=1, len_err=0.
- Route to slave 0 with backpressure: AWADDR=0x0000_1000, AWLEN=0; M0_AWREADY low 3 cycles; M0_WREADY toggling -> S_AWREADY rises the same cycle as M0_AWREADY; 1 beat accepted only when M0_WREADY=1; txn_cnt0=1.
- WLAST mismatch: AWLEN=1, WLAST asserted on beat 1 -> len_err=1 and stays 1; FSM still takes 2 beats and completes the response.
- Reset mid-burst: AWLEN=7, assert ARESETN=0 after beat 3 -> next cycle w_en=0, busy=0, counters 0; the following transaction to slave 0 completes normally.
- Counter wrap with CNT_WIDTH=2: 5 transactions to slave 1 -> txn_cnt1 sequence 1,2,3,0,1.
